// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// BURST beats into a synchronous FIFO write port, honouring fifo_full.
module fifo_wr_arb #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wren,
  output logic [DWIDTH-1:0]      fifo_din,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                   busy
);

  localparam int unsigned IDW  = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(BURST + 1);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_GRANT = 1'b1;

  logic            state, state_nxt;
  logic [IDW-1:0]  rr_ptr, rr_nxt, grant_nxt, gid_inc, pick, idx;
  logic            pick_vld;
  logic [CNTW-1:0] beat_cnt, beat_nxt, beat_inc;
  logic            cur_valid, cur_last;

  // First valid requester at or above rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(rr_ptr) + i) % NREQ);
      if (req_valid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign gid_inc   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
  assign beat_inc  = beat_cnt + CNTW'(1);
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];

  always_comb begin
    req_ready = '0;
    if (state == S_GRANT) req_ready[grant_id] = ~fifo_full;
  end

  assign fifo_wren = cur_valid & req_ready[grant_id];
  assign fifo_din  = req_data[int'(grant_id)*DWIDTH +: DWIDTH];
  assign busy      = (state == S_GRANT);

  // Next-state: arbitration in IDLE, burst termination in GRANT.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    beat_nxt  = beat_cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick;
          beat_nxt  = '0;
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!cur_valid) begin
          state_nxt = S_IDLE;
          rr_nxt    = gid_inc;
        end else if (fifo_wren) begin
          beat_nxt = beat_inc;
          if (cur_last || (beat_inc == CNTW'(BURST))) begin
            state_nxt = S_IDLE;
            rr_nxt    = gid_inc;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= beat_nxt;
      grant_id <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_fifo_wr_arb;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DWIDTH = 8;
  localparam int unsigned BURST  = 4;

  logic                   clk;
  logic                   rstn;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic                   fifo_full;
  logic                   fifo_wren;
  logic [DWIDTH-1:0]      fifo_din;
  logic [1:0]             grant_id;
  logic                   busy;

  fifo_wr_arb #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wren(fifo_wren),
    .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who holds the grant, how many beats it has written, where the next search starts.
  int m_busy, m_gid, m_beats, m_ptr;
  int obs[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    int exp_ready, exp_wren, exp_din;
    exp_ready = (m_busy != 0 && !fifo_full) ? (1 << m_gid) : 0;
    exp_wren  = (m_busy != 0 && req_valid[m_gid] && !fifo_full) ? 1 : 0;
    exp_din   = int'((req_data >> (m_gid * DWIDTH)) & 32'hFF);
    check("busy",      int'(busy),      m_busy);
    check("grant_id",  int'(grant_id),  m_gid);
    check("req_ready", int'(req_ready), exp_ready);
    check("fifo_wren", int'(fifo_wren), exp_wren);
    check("fifo_din",  int'(fifo_din),  exp_din);
  endtask

  task automatic model_update();
    if (m_busy == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_busy == 0 && req_valid[(m_ptr + k) % NREQ]) begin
          m_gid   = (m_ptr + k) % NREQ;
          m_busy  = 1;
          m_beats = 0;
        end
      end
    end else if (!req_valid[m_gid]) begin
      m_busy = 0;
      m_ptr  = (m_gid + 1) % NREQ;
    end else if (!fifo_full) begin
      m_beats++;
      if (req_last[m_gid] || m_beats == BURST) begin
        m_busy = 0;
        m_ptr  = (m_gid + 1) % NREQ;
      end
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks, advances the model.
  task automatic step(input logic [3:0] v, input logic [3:0] l, input logic f);
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = $urandom;
    #1;
    compare_outputs();
    if (fifo_wren) obs.push_back(int'(grant_id));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_busy",  int'(busy),      0);
    check("rst_wren",  int'(fifo_wren), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_gid",   int'(grant_id),  0);
    m_busy = 0; m_gid = 0; m_beats = 0; m_ptr = 0;
    obs.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] v, l;
    logic       f;
    rstn = 1'b0; req_valid = '0; req_data = '0; req_last = '0; fifo_full = 1'b0;
    do_reset();

    // Two requesters valid: 1 wins first, then 2 after 1 releases.
    step(4'b0110, 4'b0000, 1'b0);
    check("p030_busy", int'(busy), 1);
    check("p030_gid1", int'(grant_id), 1);
    step(4'b0110, 4'b0010, 1'b0);
    step(4'b0110, 4'b0000, 1'b0);
    check("p030_gid2", int'(grant_id), 2);

    // All valid, no last: BURST writes per grant, rotating 0,1,2,3,0.
    do_reset();
    repeat (25) step(4'b1111, 4'b0000, 1'b0);
    check("p031_nwr", obs.size(), 20);
    for (int j = 0; j < obs.size() && j < 20; j++)
      check("p031_seq", obs[j], (j / 4) % 4);

    // Requester 3 sends two beats ending with last, then search restarts at 0.
    do_reset();
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    check("p032_nwr", obs.size(), 2);
    check("p032_idle", int'(busy), 0);
    step(4'b1001, 4'b0000, 1'b0);
    check("p032_ptr0", int'(grant_id), 0);

    // Back-pressure mid-burst holds the grant and preserves the beat count.
    do_reset();
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    for (int j = 0; j < 5; j++) begin
      step(4'b0001, 4'b0000, 1'b1);
      check("p033_wren", int'(fifo_wren), 0);
      check("p033_ready", int'(req_ready), 0);
      check("p033_busy", int'(busy), 1);
    end
    repeat (3) step(4'b0001, 4'b0000, 1'b0);
    check("p033_nwr", obs.size(), 4);
    check("p033_idle", int'(busy), 0);

    // Granted source drops after one beat: release and advance the pointer.
    do_reset();
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0011, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    check("p034_idle", int'(busy), 0);
    step(4'b0011, 4'b0000, 1'b0);
    check("p034_gid1", int'(grant_id), 1);

    // Reset in mid-burst: outputs drop at once, next search starts at 0.
    do_reset();
    step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    check("p035_pre", int'(grant_id), 3);
    do_reset();
    step(4'b1001, 4'b0000, 1'b0);
    check("p035_gid0", int'(grant_id), 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < NREQ; b++) begin
        v[b] = ($urandom_range(0, 99) < 85);
        l[b] = ($urandom_range(0, 99) < 20);
      end
      f = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 499) == 0) do_reset();
      step(v, l, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
